// File: rtl/equiv_pkg.sv
// Shared types and helpers for the equivalence sweeper: FSM state encoding
// and the binary-to-Gray conversion used for the GRAY_ORDER_EN vector order.
`timescale 1ns/1ps
package equiv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_SAMPLE,
      ST_DONE
   } state_e;

   localparam int MAX_IN   = 16;
   localparam int SETTLE_W = 4;

   function automatic logic [MAX_IN-1:0] bin2gray(input logic [MAX_IN-1:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/sweep_counter.sv
// Sweep index register plus per-vector settle counter, with the flags the
// sweeper FSM uses to decide when to sample and when the sweep is complete.
`timescale 1ns/1ps
module sweep_counter
   import equiv_pkg::*;
#(
   parameter int N_IN   = 4,
   parameter int SETTLE = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr,
   input  logic            settle_en,
   input  logic            adv,
   output logic [N_IN-1:0] idx,
   output logic            settle_last,
   output logic            idx_last
);

   logic [N_IN-1:0]     idx_q, idx_d;
   logic [SETTLE_W-1:0] cnt_q, cnt_d;

   // Advancing the index also rearms the settle counter for the next vector.
   always_comb begin
      idx_d = idx_q;
      cnt_d = cnt_q;
      if (clr) begin
         idx_d = '0;
         cnt_d = '0;
      end else if (adv) begin
         idx_d = idx_q + 1'b1;
         cnt_d = '0;
      end else if (settle_en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q <= '0;
         cnt_q <= '0;
      end else begin
         idx_q <= idx_d;
         cnt_q <= cnt_d;
      end
   end

   assign idx         = idx_q;
   assign settle_last = (cnt_q == SETTLE_W'(SETTLE - 1));
   assign idx_last    = &idx_q;

endmodule

// File: rtl/equiv_sweeper.sv
// Exhaustive equivalence sweeper: drives every input vector to N_CH channels and
// compares each against channel 0. Define GRAY_ORDER_EN for Gray-code vector order.
`timescale 1ns/1ps
module equiv_sweeper
   import equiv_pkg::*;
#(
   parameter int N_IN   = 4,
   parameter int N_CH   = 3,
   parameter int SETTLE = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abort,
   input  logic [N_CH-1:0] ch_out,
   output logic [N_IN-1:0] vec,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   mis_cnt,
   output logic [N_CH-1:0] fail_mask,
   output logic [N_IN-1:0] first_fail_vec,
   output logic            first_fail_vld
);

   localparam state_e ST_RUN = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

   state_e          state_q, state_d;
   logic [N_IN:0]   mis_cnt_q, mis_cnt_d;
   logic [N_CH-1:0] fail_mask_q, fail_mask_d;
   logic [N_IN-1:0] ffv_q, ffv_d;
   logic            ffvld_q, ffvld_d;

   logic            clr, settle_en, adv, settle_last, idx_last;
   logic [N_IN-1:0] idx, vec_ord;
   logic [N_CH-1:0] diff;

   sweep_counter #(.N_IN(N_IN), .SETTLE(SETTLE)) u_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
      .settle_en  (settle_en),
      .adv        (adv),
      .idx        (idx),
      .settle_last(settle_last),
      .idx_last   (idx_last)
   );

`ifdef GRAY_ORDER_EN
   assign vec_ord = N_IN'(bin2gray(MAX_IN'(idx)));
`else
   assign vec_ord = idx;
`endif

   // Bit 0 compares golden with itself, so fail_mask[0] can never set.
   assign diff = ch_out ^ {N_CH{ch_out[0]}};

   always_comb begin
      state_d     = state_q;
      clr         = 1'b0;
      settle_en   = 1'b0;
      adv         = 1'b0;
      mis_cnt_d   = mis_cnt_q;
      fail_mask_d = fail_mask_q;
      ffv_d       = ffv_q;
      ffvld_d     = ffvld_q;
      if (abort || ((state_q == ST_IDLE || state_q == ST_DONE) && start)) begin
         state_d     = abort ? ST_IDLE : ST_RUN;
         clr         = 1'b1;
         mis_cnt_d   = '0;
         fail_mask_d = '0;
         ffv_d       = '0;
         ffvld_d     = 1'b0;
      end else begin
         case (state_q)
            ST_SETTLE: begin
               settle_en = 1'b1;
               if (settle_last) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
               fail_mask_d = fail_mask_q | diff;
               if (|diff) begin
                  mis_cnt_d = mis_cnt_q + 1'b1;
                  if (!ffvld_q) begin
                     ffv_d   = vec_ord;
                     ffvld_d = 1'b1;
                  end
               end
               if (idx_last) begin
                  state_d = ST_DONE;
               end else begin
                  adv     = 1'b1;
                  state_d = ST_RUN;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         mis_cnt_q   <= '0;
         fail_mask_q <= '0;
         ffv_q       <= '0;
         ffvld_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         mis_cnt_q   <= mis_cnt_d;
         fail_mask_q <= fail_mask_d;
         ffv_q       <= ffv_d;
         ffvld_q     <= ffvld_d;
      end
   end

   assign vec            = (state_q == ST_IDLE) ? '0 : vec_ord;
   assign busy           = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
   assign done           = (state_q == ST_DONE);
   assign pass           = done && (mis_cnt_q == '0);
   assign mis_cnt        = mis_cnt_q;
   assign fail_mask      = fail_mask_q;
   assign first_fail_vec = ffv_q;
   assign first_fail_vld = ffvld_q;

endmodule

// File: tb/tb_equiv_sweeper.sv
// Bench for equiv_sweeper: a SETTLE=2 instance and a SETTLE=0 instance, both
// fed by truth-table channels; results checked against a whole-sweep model.
`timescale 1ns/1ps
module tb_equiv_sweeper;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, start, abort;
   logic [2:0] ch_out;
   logic [3:0] vec, ffv;
   logic       busy, done, pass, ffvld;
   logic [4:0] mis_cnt;
   logic [2:0] fail_mask;

   logic       rst0_n, start0, abort0;
   logic [2:0] ch_out0;
   logic [3:0] vec0, ffv0;
   logic       busy0, done0, pass0, ffvld0;
   logic [4:0] mis_cnt0;
   logic [2:0] fail_mask0;

   logic [15:0] g, t1, t2;
   logic        sel;

   assign ch_out  = {t2[vec],  t1[vec],  g[vec]};
   assign ch_out0 = {t2[vec0], t1[vec0], g[vec0]};

   equiv_sweeper #(.N_IN(4), .N_CH(3), .SETTLE(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ch_out(ch_out),
      .vec(vec), .busy(busy), .done(done), .pass(pass), .mis_cnt(mis_cnt),
      .fail_mask(fail_mask), .first_fail_vec(ffv), .first_fail_vld(ffvld));

   equiv_sweeper #(.N_IN(4), .N_CH(3), .SETTLE(0)) dut0 (
      .clk(clk), .rst_n(rst0_n), .start(start0), .abort(abort0), .ch_out(ch_out0),
      .vec(vec0), .busy(busy0), .done(done0), .pass(pass0), .mis_cnt(mis_cnt0),
      .fail_mask(fail_mask0), .first_fail_vec(ffv0), .first_fail_vld(ffvld0));

   logic [3:0] s_vec, s_ffv;
   logic       s_busy, s_done, s_pass, s_ffvld;
   logic [4:0] s_mis;
   logic [2:0] s_mask;
   always_comb begin
      s_vec   = sel ? vec0       : vec;
      s_ffv   = sel ? ffv0       : ffv;
      s_busy  = sel ? busy0      : busy;
      s_done  = sel ? done0      : done;
      s_pass  = sel ? pass0      : pass;
      s_ffvld = sel ? ffvld0     : ffvld;
      s_mis   = sel ? mis_cnt0   : mis_cnt;
      s_mask  = sel ? fail_mask0 : fail_mask;
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Vector presented at sweep position i.
   function automatic logic [3:0] ord(input int i);
      logic [3:0] b;
      b = 4'(i);
`ifdef GRAY_ORDER_EN
      return b ^ (b >> 1);
`else
      return b;
`endif
   endfunction

   function automatic void model(input logic [15:0] mg, ma, mb,
                                 output logic [4:0] mis, output logic [2:0] mask,
                                 output logic [3:0] fv, output logic fvld);
      mis = '0; mask = '0; fv = '0; fvld = 1'b0;
      for (int i = 0; i < 16; i++) begin
         logic [3:0] v;
         logic       d1, d2;
         v  = ord(i);
         d1 = (ma[v] != mg[v]);
         d2 = (mb[v] != mg[v]);
         if (d1) mask[1] = 1'b1;
         if (d2) mask[2] = 1'b1;
         if (d1 || d2) begin
            mis = mis + 1'b1;
            if (!fvld) begin
               fv   = v;
               fvld = 1'b1;
            end
         end
      end
   endfunction

   task automatic set_start(input logic v);
      if (sel) start0 = v; else start = v;
   endtask

   task automatic set_abort(input logic v);
      if (sel) abort0 = v; else abort = v;
   endtask

   // Start a sweep on the selected DUT and count busy cycles, checking the vector
   // held at each one; optionally pulse start or assert abort at a busy cycle.
   task automatic sweep(input int pulse_at, input int abort_at, output int nb);
      int         per, verr, herr;
      logic [3:0] pv;
      per  = sel ? 1 : 3;
      verr = 0;
      herr = 0;
      pv   = '0;
      @(negedge clk);
      set_start(1'b1);
      @(negedge clk);
      set_start(1'b0);
      nb = 0;
      while (s_busy && nb < 200) begin
         if (nb == pulse_at + 1) set_start(1'b0);
         if (s_vec !== ord(nb / per)) verr++;
         if (nb > 0 && s_vec != pv && $countones(s_vec ^ pv) != 1) herr++;
         pv = s_vec;
         if (nb == pulse_at) set_start(1'b1);
         if (nb == abort_at) begin
            set_abort(1'b1);
            @(negedge clk);
            set_abort(1'b0);
            break;
         end
         nb++;
         @(negedge clk);
      end
      set_start(1'b0);
      chk("vec_seq", verr, 0);
`ifdef GRAY_ORDER_EN
      chk("gray_hamming", herr, 0);
`endif
   endtask

   task automatic check_res(input logic [4:0] mis, input logic [2:0] mask,
                            input logic [3:0] fv, input logic fvld);
      chk("done", s_done, 1'b1);
      chk("mis_cnt", s_mis, mis);
      chk("fail_mask", s_mask, mask);
      chk("first_fail_vld", s_ffvld, fvld);
      chk("first_fail_vec", s_ffv, fv);
      chk("pass", s_pass, (mis == 0));
   endtask

   typedef struct {
      logic [15:0] g, t1, t2;
      logic [4:0]  mis;
      logic [2:0]  mask;
      logic [3:0]  ffv;
      logic        ffvld;
   } vec_t;

   vec_t tbl[5];

   initial begin
      int         nb;
      logic [4:0] em;
      logic [2:0] ek;
      logic [3:0] ef;
      logic       ev;

      tbl[0] = '{16'h6996, 16'h6996,           16'h6996,           5'd0,  3'b000, 4'h0, 1'b0};
      tbl[1] = '{16'h007F, 16'h007F,           16'h0000,           5'd7,  3'b100, 4'h0, 1'b1};
      tbl[2] = '{16'h3C5A, 16'h3C5A ^ 16'h0400, 16'h3C5A,           5'd1,  3'b010, 4'hA, 1'b1};
      tbl[3] = '{16'h1234, ~16'h1234,          16'h1234,           5'd16, 3'b010, 4'h0, 1'b1};
      tbl[4] = '{16'hF0F0, 16'hF0F0 ^ 16'h0020, 16'hF0F0 ^ 16'h0220, 5'd2,  3'b110, 4'h5, 1'b1};

      sel = 1'b0;
      g = '0; t1 = '0; t2 = '0;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      rst0_n = 1'b0; start0 = 1'b0; abort0 = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      rst0_n = 1'b1;
      @(negedge clk);
      chk("reset_outputs", {vec, busy, done, pass, mis_cnt, fail_mask, ffv, ffvld}, '0);
      chk("reset_outputs0", {vec0, busy0, done0, pass0, mis_cnt0, fail_mask0, ffv0, ffvld0}, '0);

      for (int i = 0; i < 5; i++) begin
         g = tbl[i].g; t1 = tbl[i].t1; t2 = tbl[i].t2;
         sweep(-1, -1, nb);
         chk("busy_cycles", nb, 48);
         check_res(tbl[i].mis, tbl[i].mask, tbl[i].ffv, tbl[i].ffvld);
      end

      repeat (5) @(negedge clk);
      chk("done_hold_vec", vec, ord(15));
      check_res(5'd2, 3'b110, 4'h5, 1'b1);

      g = tbl[2].g; t1 = tbl[2].t1; t2 = tbl[2].t2;
      sweep(10, -1, nb);
      chk("busy_cycles_start_pulse", nb, 48);
      check_res(5'd1, 3'b010, 4'hA, 1'b1);

      g = tbl[3].g; t1 = tbl[3].t1; t2 = tbl[3].t2;
      sweep(-1, 20, nb);
      chk("abort_cleared", {vec, busy, done, pass, mis_cnt, fail_mask, ffv, ffvld}, '0);

      g = tbl[1].g; t1 = tbl[1].t1; t2 = tbl[1].t2;
      sweep(-1, -1, nb);
      chk("done_before_abort_start", done, 1'b1);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("abort_beats_start", {busy, done, mis_cnt, fail_mask, ffvld}, '0);

      for (int r = 0; r < 6; r++) begin
         g  = 16'($urandom);
         t1 = (r == 0) ? g : g ^ (16'($urandom) & 16'($urandom));
         t2 = g ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
         model(g, t1, t2, em, ek, ef, ev);
         sweep(-1, -1, nb);
         chk("busy_cycles_rand", nb, 48);
         check_res(em, ek, ef, ev);
      end

      sel = 1'b1;
      g = 16'hA5C3; t1 = 16'h5A3C; t2 = 16'hA5C3;
      @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (5) @(negedge clk);
      chk("midsweep_busy0", busy0, 1'b1);
      rst0_n = 1'b0;
      @(negedge clk);
      chk("midsweep_reset0", {vec0, busy0, done0, pass0, mis_cnt0, fail_mask0, ffv0, ffvld0}, '0);
      rst0_n = 1'b1;
      @(negedge clk);
      g = 16'($urandom); t1 = g; t2 = g ^ 16'h8001;
      model(g, t1, t2, em, ek, ef, ev);
      sweep(-1, -1, nb);
      chk("busy_cycles_settle0", nb, 16);
      check_res(em, ek, ef, ev);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/equiv_sweeper.md
EQUIV_SWEEPER -- requirements
Module: equiv_sweeper

Interface
REQ-001 SHALL have parameter N_IN, default 4: number of boolean-function inputs swept (2..16).
REQ-002 SHALL have parameter N_CH, default 3: number of implementation channels compared (2..8); channel 0 is golden.
REQ-003 SHALL have parameter SETTLE, default 2: extra hold cycles per vector before sampling (0..15).
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-006 SHALL have port start  input  1  begin sweep; accepted only in IDLE or DONE.
REQ-007 SHALL have port abort  input  1  cancel sweep and return to IDLE.
REQ-008 SHALL have port ch_out  input  N_CH  function output of each implementation under test.
REQ-009 SHALL have port vec  output  N_IN  input vector driven to all implementations.
REQ-010 SHALL have port busy  output  1  high in SETTLE and SAMPLE.
REQ-011 SHALL have port done  output  1  high while in DONE.
REQ-012 SHALL have port pass  output  1  valid when done; 1 iff zero mismatches.
REQ-013 SHALL have port mis_cnt  output  N_IN+1  number of vectors where any channel differed from channel 0.
REQ-014 SHALL have port fail_mask  output  N_CH  sticky per-channel mismatch flags; bit 0 always 0.
REQ-015 SHALL have port first_fail_vec  output  N_IN  vec value at first mismatching sample.
REQ-016 SHALL have port first_fail_vld  output  1  first_fail_vec holds a captured value.

Function
REQ-017 SHALL implement FSM states IDLE, SETTLE, SAMPLE, DONE.
REQ-018 SHALL, on start in IDLE/DONE, go to SETTLE next cycle with index=0, settle counter=0, and mis_cnt, fail_mask, first_fail_vld cleared.
REQ-019 SHALL hold vec constant for exactly SETTLE+1 cycles per index: SETTLE cycles in SETTLE (skipped when SETTLE=0), then one SAMPLE cycle.
REQ-020 SHALL, in SAMPLE, compare ch_out[k] with ch_out[0] for k=1..N_CH-1, set fail_mask[k] on inequality, and increment mis_cnt by 1 if any bit differs.
REQ-021 SHALL capture vec into first_fail_vec and set first_fail_vld on the first mismatching SAMPLE only.
REQ-022 SHALL, after SAMPLE at last index (2^N_IN-1), enter DONE; otherwise increment index and re-enter SETTLE.
REQ-023 SHALL complete a sweep in 2^N_IN*(SETTLE+1) busy cycles; done rises the following cycle.
REQ-024 SHALL hold all result outputs stable in DONE until next start or reset.
REQ-025 SHALL ignore start while busy.
REQ-026 SHALL, on abort in any state, go to IDLE next cycle with results cleared; abort wins over simultaneous start.
REQ-027 SHALL drive vec=0 in IDLE and hold last vec in DONE.
REQ-028 SHALL not wrap mis_cnt; N_IN+1 bits holds the maximum 2^N_IN.

Reset
REQ-029 SHALL, with rst_n=0 at a rising edge, enter IDLE with vec=0, busy=0, done=0, pass=0, mis_cnt=0, fail_mask=0, first_fail_vec=0, first_fail_vld=0.
REQ-030 SHALL let reset mid-sweep discard the sweep entirely; reset overrides start and abort.

Configuration
REQ-031 SHALL, with GRAY_ORDER_EN defined, drive vec = index ^ (index>>1) so consecutive vectors differ in one bit; without it vec = index (binary order).
REQ-032 SHALL report first_fail_vec as the driven vec value in both orders.

Structure
REQ-033 SHALL place the state enum type and a bin2gray function in package equiv_pkg.
REQ-034 SHALL use one sub-module sweep_counter (index register, settle counter, last/tick flags); FSM and compare logic stay in equiv_sweeper.

Verification (N_IN=4, N_CH=3, SETTLE=2 unless stated)
REQ-035 SHALL test identical channels: start -> done after 48 busy cycles, pass=1, mis_cnt=0, fail_mask=000.
REQ-036 SHALL test channel 2 stuck-at-0 against a golden with 7 minterms -> mis_cnt=7, fail_mask=100, pass=0.
REQ-037 SHALL test channel 1 wrong only at vec=0xA (binary order) -> mis_cnt=1, first_fail_vec=0xA, first_fail_vld=1.
REQ-038 SHALL test abort at busy cycle 20, and separately start pulsed at cycle 10 -> abort returns to IDLE with results cleared next cycle; the start pulse leaves the sweep unchanged.
REQ-039 SHALL test GRAY_ORDER_EN -> vec sequence 0,1,3,2,6,7,5,4,... each held 3 cycles; Hamming distance 1 between successive vectors.
REQ-040 SHALL test rst_n low mid-sweep, SETTLE=0 -> all outputs at reset values next cycle; a new sweep then finishes in 16 busy cycles.
